// File: rtl/adc_pkg.sv
// Shared definitions for the ADC volt meter.
// Holds the FSM state encoding and the BCD sizing helpers.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_QUIET    = 3'd3,
    ST_ACCUM    = 3'd4,
    ST_SCALE    = 3'd5,
    ST_BCD      = 3'd6,
    ST_OUTPUT   = 3'd7
  } state_t;

  // Decimal digits needed to hold any w-bit unsigned value.
  function automatic int bcd_digits(input int w);
    longint unsigned max_v;
    int n;
    max_v = (64'd1 << w) - 64'd1;
    n = 32'sd1;
    for (int i = 0; i < 20; i++) begin
      if (max_v >= 64'd10) begin
        max_v = max_v / 64'd10;
        n = n + 32'sd1;
      end else begin
        max_v = max_v;
      end
    end
    return n;
  endfunction

  function automatic int bcd_width(input int w);
    return 32'sd4 * bcd_digits(w);
  endfunction

  function automatic int pow10(input int d);
    int p;
    p = 32'sd1;
    for (int i = 0; i < d; i++) p = p * 32'sd10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per clock.
// Output saturates to all nines when the value needs more than DIGITS digits.
module bin2bcd_seq
  import adc_pkg::*;
#(
  parameter int IN_W   = 9,
  parameter int DIGITS = 3
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                start,
  input  logic [IN_W-1:0]     bin,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int FULL_W = bcd_width(IN_W);
  localparam int CNT_W  = $clog2(IN_W + 1);

  logic [IN_W-1:0]     bin_r;
  logic [FULL_W-1:0]   acc_r;
  logic [FULL_W-1:0]   adj_s;
  logic [FULL_W-1:0]   acc_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic                run_r;
  logic                done_r;
  logic                last_s;
  logic                sat_s;
  logic [4*DIGITS-1:0] bcd_r;
  logic [4*DIGITS-1:0] bcd_nxt_s;

  // One conversion step: add 3 to digits >= 5, then shift in the next MSB.
  always_comb begin
    adj_s = acc_r;
    for (int i = 0; i < FULL_W / 4; i++) begin
      if (acc_r[4*i +: 4] >= 4'd5) adj_s[4*i +: 4] = acc_r[4*i +: 4] + 4'd3;
      else                         adj_s[4*i +: 4] = acc_r[4*i +: 4];
    end
    acc_nxt_s = {adj_s[FULL_W-2:0], bin_r[IN_W-1]};
    last_s    = (cnt_r == CNT_W'(1));
    sat_s     = ((acc_nxt_s >> (4 * DIGITS)) != {FULL_W{1'b0}});
    if (sat_s) bcd_nxt_s = {DIGITS{4'h9}};
    else       bcd_nxt_s = (4 * DIGITS)'(acc_nxt_s);
  end

  // Conversion sequencer; done pulses for one cycle with the result.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bin_r  <= {IN_W{1'b0}};
      acc_r  <= {FULL_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      run_r  <= 1'b0;
      done_r <= 1'b0;
      bcd_r  <= {(4*DIGITS){1'b0}};
    end else if (start) begin
      bin_r  <= bin;
      acc_r  <= {FULL_W{1'b0}};
      cnt_r  <= CNT_W'(IN_W);
      run_r  <= 1'b1;
      done_r <= 1'b0;
    end else if (run_r) begin
      bin_r <= {bin_r[IN_W-2:0], 1'b0};
      acc_r <= acc_nxt_s;
      cnt_r <= cnt_r - CNT_W'(1);
      if (last_s) begin
        run_r  <= 1'b0;
        done_r <= 1'b1;
        bcd_r  <= bcd_nxt_s;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done = done_r;
  assign bcd  = bcd_r;

endmodule

// File: rtl/adc_volt_meter_p.sv
// Serial ADC volt meter: reads frames over a clk_in-derived SPI-like link,
// averages, scales to volts and presents binary and BCD results.
module adc_volt_meter_p
  import adc_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 12,
  parameter int LEAD_BITS = 3,
  parameter int QUIET     = 4,
  parameter int AVG_LOG2  = 0,
  parameter int SCALE     = 132,
  parameter int SHIFT     = 10,
  parameter int DIGITS    = 3
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                start,
  input  logic                cont,
  input  logic                adc_in,
  output logic                adc_clk,
  output logic                adc_csn,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_raw,
  output logic [DATA_W:0]     res_bin,
  output logic [4*DIGITS-1:0] res_bcd,
  output logic                busy,
  output logic                overrun
);

  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int PROD_W = DATA_W + 34;
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV);
  localparam logic [7:0] LEAD_LAST  = 8'(LEAD_BITS - 32'sd1);
  localparam logic [7:0] BIT_LAST   = 8'(DATA_W - 32'sd1);
  localparam logic [7:0] QUIET_LAST = 8'(QUIET - 32'sd1);
  localparam logic [4:0] SAMP_LAST  = 5'((32'sd1 << AVG_LOG2) - 32'sd1);
  localparam logic [PROD_W-1:0] DEC_MAX = PROD_W'(pow10(DIGITS) - 32'sd1);

  state_t              state_r, next_s;
  logic [7:0]          div_cnt_r, cnt_r;
  logic                adc_clk_r, csn_r, rise_en_s;
  logic [4:0]          samp_cnt_r;
  logic [ACC_W-1:0]    acc_r, acc_sum_s;
  logic [DATA_W-1:0]   shift_r, avg_r, avg_s;
  logic [DATA_W:0]     bin_r;
  logic [PROD_W-1:0]   scaled_s;
  logic                sat_r, busy_r, valid_r, ovr_r;
  logic                lead_done_s, bits_done_s, quiet_done_s, samp_done_s;
  logic                bcd_start_s, bcd_done_s, load_s;
  logic [DATA_W-1:0]   raw_r;
  logic [DATA_W:0]     res_bin_r;
  logic [4*DIGITS-1:0] res_bcd_r, bcd_s;

  // Edge detect and datapath arithmetic shared by the FSM and datapath.
  always_comb begin
    rise_en_s    = (div_cnt_r == DIV_LAST) && !adc_clk_r;
    lead_done_s  = csn_r ? (LEAD_BITS == 32'sd0) : (cnt_r == LEAD_LAST);
    bits_done_s  = (cnt_r == BIT_LAST);
    quiet_done_s = (cnt_r == QUIET_LAST);
    samp_done_s  = (samp_cnt_r == SAMP_LAST);
    acc_sum_s    = acc_r + ACC_W'(shift_r);
    avg_s        = DATA_W'(acc_sum_s >> AVG_LOG2);
    scaled_s     = (PROD_W'(avg_r) * PROD_W'(SCALE) + PROD_W'(SCALE)) >> SHIFT;
  end

  // adc_clk divider; rise_en marks the clk_in edge on which adc_clk rises.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_cnt_r <= 8'd0;
      adc_clk_r <= 1'b0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= 8'd0;
      adc_clk_r <= ~adc_clk_r;
    end else begin
      div_cnt_r <= div_cnt_r + 8'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_r <= ST_IDLE;
    else           state_r <= next_s;
  end

  // FSM next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE:     if (start || cont) next_s = ST_CS_SETUP; else next_s = ST_IDLE;
      ST_CS_SETUP: if (rise_en_s && lead_done_s) next_s = ST_SHIFT; else next_s = ST_CS_SETUP;
      ST_SHIFT:    if (rise_en_s && bits_done_s) next_s = ST_QUIET; else next_s = ST_SHIFT;
      ST_QUIET:    if (rise_en_s && quiet_done_s) next_s = ST_ACCUM; else next_s = ST_QUIET;
      ST_ACCUM:    if (samp_done_s) next_s = ST_SCALE; else next_s = ST_CS_SETUP;
      ST_SCALE:    next_s = ST_BCD;
      ST_BCD:      if (bcd_done_s) next_s = ST_OUTPUT; else next_s = ST_BCD;
      ST_OUTPUT:   next_s = ST_IDLE;
      default:     next_s = ST_IDLE;
    endcase
  end

  // FSM control strobes.
  always_comb begin
    bcd_start_s = 1'b0;
    load_s      = 1'b0;
    case (state_r)
      ST_SCALE:  bcd_start_s = 1'b1;
      ST_OUTPUT: load_s      = 1'b1;
      default: begin
        bcd_start_s = 1'b0;
        load_s      = 1'b0;
      end
    endcase
  end

  // Frame datapath: chip select, edge counters, shift register, accumulator.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      csn_r      <= 1'b1;
      cnt_r      <= 8'd0;
      samp_cnt_r <= 5'd0;
      acc_r      <= {ACC_W{1'b0}};
      shift_r    <= {DATA_W{1'b0}};
      avg_r      <= {DATA_W{1'b0}};
      bin_r      <= {(DATA_W+1){1'b0}};
      sat_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r      <= 8'd0;
          samp_cnt_r <= 5'd0;
          acc_r      <= {ACC_W{1'b0}};
        end
        ST_CS_SETUP: if (rise_en_s) begin
          // csn drops on the first edge; lead edges are counted after that
          if (csn_r)            csn_r <= 1'b0;
          else if (lead_done_s) cnt_r <= 8'd0;
          else                  cnt_r <= cnt_r + 8'd1;
        end
        ST_SHIFT: if (rise_en_s) begin
          shift_r <= {shift_r[DATA_W-2:0], adc_in};
          if (bits_done_s) begin
            csn_r <= 1'b1;
            cnt_r <= 8'd0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_QUIET: if (rise_en_s) cnt_r <= quiet_done_s ? 8'd0 : cnt_r + 8'd1;
        ST_ACCUM: begin
          if (samp_done_s) begin
            avg_r      <= avg_s;
            acc_r      <= {ACC_W{1'b0}};
            samp_cnt_r <= 5'd0;
          end else begin
            acc_r      <= acc_sum_s;
            samp_cnt_r <= samp_cnt_r + 5'd1;
          end
        end
        ST_SCALE: begin
          bin_r <= scaled_s[DATA_W:0];
          sat_r <= (scaled_s > DEC_MAX);
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  bin2bcd_seq #(
    .IN_W  (DATA_W + 1),
    .DIGITS(DIGITS)
  ) u_bcd (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .start   (bcd_start_s),
    .bin     (scaled_s[DATA_W:0]),
    .done    (bcd_done_s),
    .bcd     (bcd_s)
  );

  // Result holding registers with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      ovr_r     <= 1'b0;
      raw_r     <= {DATA_W{1'b0}};
      res_bin_r <= {(DATA_W+1){1'b0}};
      res_bcd_r <= {(4*DIGITS){1'b0}};
    end else begin
      busy_r <= (next_s != ST_IDLE);
      if (load_s) begin
        valid_r   <= 1'b1;
        raw_r     <= avg_r;
        res_bin_r <= bin_r;
        res_bcd_r <= sat_r ? {DIGITS{4'h9}} : bcd_s;
        if (valid_r && !res_ready) ovr_r <= 1'b1;
      end else if (res_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign adc_clk   = adc_clk_r;
  assign adc_csn   = csn_r;
  assign res_valid = valid_r;
  assign res_raw   = raw_r;
  assign res_bin   = res_bin_r;
  assign res_bcd   = res_bcd_r;
  assign busy      = busy_r;
  assign overrun   = ovr_r;

endmodule

// File: tb/tb_adc_volt_meter_p.sv
// Self-checking bench for adc_volt_meter_p: table vectors, random codes
// against an arithmetic reference model, and multi-cycle corner sequences.
module tb_adc_volt_meter_p;

  localparam int LEAD = 3;
  localparam int W    = 8;

  typedef struct {
    logic [7:0]  code;
    logic [8:0]  exp_bin;
    logic [11:0] exp_bcd;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_n_in;
  always #5 clk_in = ~clk_in;

  logic adc_in, adc_in3;
  logic start1, cont1, ready1, valid1, busy1, ovr1, adc_clk1, csn1;
  logic [7:0] raw1; logic [8:0] bin1; logic [11:0] bcd1;
  logic start2, cont2, ready2, valid2, busy2, ovr2, adc_clk2, csn2;
  logic [7:0] raw2; logic [8:0] bin2; logic [11:0] bcd2;
  logic start3, cont3, ready3, valid3, busy3, ovr3, adc_clk3, csn3;
  logic [11:0] raw3; logic [12:0] bin3; logic [11:0] bcd3;

  int n_checks = 0;
  int n_fail = 0;
  int low_edges = 0;
  int frames = 0;
  bit sel = 1'b0;
  logic [7:0] codes[$];

  adc_volt_meter_p #(.CLK_DIV(1)) dut1 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start(start1), .cont(cont1), .adc_in(adc_in),
    .adc_clk(adc_clk1), .adc_csn(csn1), .res_valid(valid1), .res_ready(ready1),
    .res_raw(raw1), .res_bin(bin1), .res_bcd(bcd1), .busy(busy1), .overrun(ovr1));

  adc_volt_meter_p #(.CLK_DIV(1), .AVG_LOG2(2)) dut2 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start(start2), .cont(cont2), .adc_in(adc_in),
    .adc_clk(adc_clk2), .adc_csn(csn2), .res_valid(valid2), .res_ready(ready2),
    .res_raw(raw2), .res_bin(bin2), .res_bcd(bcd2), .busy(busy2), .overrun(ovr2));

  adc_volt_meter_p #(.DATA_W(12), .CLK_DIV(1), .SCALE(4096), .SHIFT(10), .DIGITS(3)) dut3 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start(start3), .cont(cont3), .adc_in(adc_in3),
    .adc_clk(adc_clk3), .adc_csn(csn3), .res_valid(valid3), .res_ready(ready3),
    .res_raw(raw3), .res_bin(bin3), .res_bcd(bcd3), .busy(busy3), .overrun(ovr3));

  // ADC serial model and link monitor for the selected 8-bit DUT.
  initial begin
    logic ck, cs, ck_q, cs_q;
    int n_neg;
    logic [7:0] cur;
    adc_in = 1'b0; ck_q = 1'b0; cs_q = 1'b1; n_neg = 0; cur = 8'd0;
    forever begin
      @(negedge clk_in);
      ck = sel ? adc_clk2 : adc_clk1;
      cs = sel ? csn2 : csn1;
      if (ck && !ck_q && !cs_q) low_edges++;
      if (cs_q && !cs) frames++;
      if (!ck && ck_q) begin
        if (cs) n_neg = 0;
        else begin
          n_neg++;
          if (n_neg == 1) cur = (codes.size() > 0) ? codes.pop_front() : 8'($urandom_range(255, 0));
          if (n_neg > LEAD && n_neg <= LEAD + W) adc_in = cur[W - 1 - (n_neg - LEAD - 1)];
          else adc_in = 1'($urandom_range(1, 0));
        end
      end
      ck_q = ck;
      cs_q = cs;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model(input int sum, input int avg_log2, input int w, input int scale,
                                output int raw, output int bin, output int bcd);
    int full;
    raw  = sum >> avg_log2;
    full = ((raw + 1) * scale) >> 10;
    bin  = full % (1 << (w + 1));
    if (full > 999) bcd = 'h999;
    else bcd = ((bin / 100) % 10) * 256 + ((bin / 10) % 10) * 16 + (bin % 10);
  endfunction

  task automatic wait_for(input int what, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(negedge clk_in);
      case (what)
        0: hit = valid1;
        1: hit = valid2;
        2: hit = valid3;
        3: hit = ovr1;
        4: hit = busy1;
        default: hit = 1'b1;
      endcase
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout %s", name);
    end
  endtask

  task automatic pulse1();
    @(negedge clk_in) start1 = 1'b1;
    @(negedge clk_in) start1 = 1'b0;
  endtask

  task automatic ack1(input string name);
    @(negedge clk_in) ready1 = 1'b1;
    @(negedge clk_in) ready1 = 1'b0;
    check({name, " valid cleared"}, valid1, 0);
  endtask

  task automatic run1(input logic [7:0] code, input int er, input int eb, input int ed, input string name);
    low_edges = 0;
    frames = 0;
    codes.push_back(code);
    pulse1();
    wait_for(0, name);
    check({name, " raw"}, raw1, er);
    check({name, " bin"}, bin1, eb);
    check({name, " bcd"}, bcd1, ed);
    check({name, " csn low edges"}, low_edges, 11);
    check({name, " frames"}, frames, 1);
    ack1(name);
  endtask

  vec_t vecs[6];
  int r, b, d, sum;
  logic [7:0] c;

  initial begin
    vecs[0] = '{8'hFF, 9'd33, 12'h033};
    vecs[1] = '{8'h80, 9'd16, 12'h016};
    vecs[2] = '{8'h00, 9'd0,  12'h000};
    vecs[3] = '{8'h7F, 9'd16, 12'h016};
    vecs[4] = '{8'h40, 9'd8,  12'h008};
    vecs[5] = '{8'hC8, 9'd25, 12'h025};
    start1 = 1'b0; cont1 = 1'b0; ready1 = 1'b0;
    start2 = 1'b0; cont2 = 1'b0; ready2 = 1'b0;
    start3 = 1'b0; cont3 = 1'b0; ready3 = 1'b0; adc_in3 = 1'b1;
    rst_n_in = 1'b0;
    #7;
    check("reset adc_clk", adc_clk1, 0);
    check("reset adc_csn", csn1, 1);
    check("reset res_valid", valid1, 0);
    check("reset res_raw", raw1, 0);
    check("reset res_bin", bin1, 0);
    check("reset res_bcd", bcd1, 0);
    check("reset busy", busy1, 0);
    check("reset overrun", ovr1, 0);
    @(negedge clk_in) rst_n_in = 1'b1;
    repeat (3) @(negedge clk_in);

    for (int i = 0; i < 6; i++) run1(vecs[i].code, vecs[i].code, vecs[i].exp_bin, vecs[i].exp_bcd, "table");

    repeat (8) begin
      c = 8'($urandom_range(255, 0));
      model(c, 0, 8, 132, r, b, d);
      run1(c, r, b, d, "random");
    end

    // start pulse while busy must not launch a second frame
    low_edges = 0; frames = 0;
    codes.push_back(8'h5A);
    pulse1();
    repeat (30) @(negedge clk_in);
    pulse1();
    wait_for(0, "busy start");
    check("busy start raw", raw1, 8'h5A);
    ack1("busy start");
    repeat (300) @(negedge clk_in);
    check("busy start frames", frames, 1);
    check("busy start idle", busy1, 0);

    // two back-to-back results without acceptance
    frames = 0;
    codes.push_back(8'h11);
    codes.push_back(8'h22);
    cont1 = 1'b1;
    wait_for(0, "overrun first");
    check("overrun first raw", raw1, 8'h11);
    check("overrun not yet", ovr1, 0);
    wait_for(4, "overrun restart");
    cont1 = 1'b0;
    wait_for(3, "overrun set");
    model(8'h22, 0, 8, 132, r, b, d);
    check("overrun second raw", raw1, r);
    check("overrun second bin", bin1, b);
    check("overrun valid", valid1, 1);
    check("overrun flag", ovr1, 1);
    ack1("overrun");
    check("overrun sticky", ovr1, 1);
    repeat (300) @(negedge clk_in);
    check("cont stop frames", frames, 2);
    check("cont stop idle", busy1, 0);

    // asynchronous reset in the middle of a data shift
    codes.push_back(8'hA5);
    low_edges = 0;
    pulse1();
    for (int i = 0; i < 2000 && low_edges < 6; i++) @(negedge clk_in);
    check("mid shift reached", csn1, 0);
    #1 rst_n_in = 1'b0;
    #1;
    check("async reset adc_csn", csn1, 1);
    check("async reset adc_clk", adc_clk1, 0);
    check("async reset busy", busy1, 0);
    check("async reset overrun", ovr1, 0);
    @(negedge clk_in) rst_n_in = 1'b1;
    codes.delete();
    repeat (3) @(negedge clk_in);
    model(8'h3C, 0, 8, 132, r, b, d);
    run1(8'h3C, r, b, d, "after reset");

    // averaging instance
    sel = 1'b1;
    repeat (10) @(negedge clk_in);
    frames = 0; low_edges = 0;
    codes.push_back(8'd10); codes.push_back(8'd20);
    codes.push_back(8'd30); codes.push_back(8'd40);
    @(negedge clk_in) start2 = 1'b1;
    @(negedge clk_in) start2 = 1'b0;
    wait_for(1, "avg fixed");
    check("avg raw", raw2, 25);
    check("avg bin", bin2, 3);
    check("avg bcd", bcd2, 12'h003);
    check("avg frames", frames, 4);
    check("avg csn low edges", low_edges, 44);
    @(negedge clk_in) ready2 = 1'b1;
    @(negedge clk_in) ready2 = 1'b0;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      c = 8'($urandom_range(255, 0));
      sum += c;
      codes.push_back(c);
    end
    model(sum, 2, 8, 132, r, b, d);
    @(negedge clk_in) start2 = 1'b1;
    @(negedge clk_in) start2 = 1'b0;
    wait_for(1, "avg random");
    check("avg random raw", raw2, r);
    check("avg random bin", bin2, b);
    check("avg random bcd", bcd2, d);

    // 12-bit instance saturating the decimal display
    model(4095, 0, 12, 4096, r, b, d);
    @(negedge clk_in) start3 = 1'b1;
    @(negedge clk_in) start3 = 1'b0;
    wait_for(2, "saturate");
    check("saturate raw", raw3, r);
    check("saturate bin", bin3, b);
    check("saturate bcd", bcd3, d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_volt_meter_p.md
ADC_VOLT_METER_P -- requirements
Module: adc_volt_meter_p

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_in and rst_n_in; polarity and synchronicity are fixed.
REQ-002 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 8, ADC code width (8..12).
- CLK_DIV, 12, adc_clk half-period minus one, in clk_in cycles (1..255).
- LEAD_BITS, 3, adc_clk rising edges after adc_csn falls before the MSB is valid.
- QUIET, 4, adc_clk rising edges with adc_csn high between frames (min 1).
- AVG_LOG2, 0, log2 of samples averaged per result (0..4).
- SCALE, 132, volt multiplier.
- SHIFT, 10, right shift after multiply.
- DIGITS, 3, BCD output digits (1..4).
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_in, in, 1, system clock.
- rst_n_in, in, 1, async active-low reset.
- start, in, 1, single-result request pulse.
- cont, in, 1, level; 1 = back-to-back conversions.
- adc_in, in, 1, ADC serial data.
- adc_clk, out, 1, ADC serial clock.
- adc_csn, out, 1, ADC chip select, active low.
- res_valid, out, 1, result available.
- res_ready, in, 1, consumer accepts result.
- res_raw, out, DATA_W, averaged code.
- res_bin, out, DATA_W+1, scaled binary value.
- res_bcd, out, 4*DIGITS, BCD of res_bin.
- busy, out, 1, FSM not in IDLE.
- overrun, out, 1, sticky: a result was dropped.

Function
REQ-004 adc_clk SHALL be derived in the clk_in domain: divider counts 0..CLK_DIV, toggles adc_clk at CLK_DIV; a one-cycle rise_en marks each rising edge; no logic SHALL be clocked by adc_clk.
REQ-005 The FSM SHALL have states IDLE, CS_SETUP, SHIFT, QUIET, ACCUM, SCALE, BCD, OUTPUT; all transitions except IDLE exit occur on rise_en or on clk_in as stated below.
REQ-006 IDLE -> CS_SETUP when start=1 or cont=1; adc_csn goes low on the next rise_en.
REQ-007 CS_SETUP SHALL ignore LEAD_BITS rise_en edges, then SHIFT samples adc_in on DATA_W rise_en edges, MSB first.
REQ-008 After the LSB, adc_csn SHALL go high on the same clk_in edge and QUIET rise_en edges SHALL elapse.
REQ-009 ACCUM SHALL add the code to a DATA_W+AVG_LOG2 accumulator; if fewer than 2^AVG_LOG2 samples are taken, return to CS_SETUP, else res_raw candidate = acc >> AVG_LOG2.
REQ-010 SCALE SHALL compute (avg*SCALE + SCALE) >> SHIFT in one clk_in cycle, full-width product, truncated to DATA_W+1 bits.
REQ-011 BCD SHALL use shift-add-3 conversion, one bit per clk_in cycle, DATA_W+1 cycles; values exceeding 10^DIGITS-1 SHALL saturate to all-9s.
REQ-012 OUTPUT SHALL load res_raw/res_bin/res_bcd and set res_valid in one clk_in cycle, then return to IDLE.
REQ-013 res_valid SHALL stay high with stable data until a clk_in edge with res_ready=1; it clears on that edge unless a new result loads on the same edge (new result wins, valid stays 1).
REQ-014 If OUTPUT occurs while res_valid=1 and res_ready=0, the new result SHALL overwrite and overrun SHALL set; overrun clears only on reset.
REQ-015 start while busy SHALL be ignored; cont falling mid-frame SHALL finish the current result.

Reset
REQ-016 On rst_n_in low, immediately: adc_clk=0, adc_csn=1, FSM=IDLE, divider/accumulator/sample count=0, res_valid=0, res_raw/res_bin/res_bcd=0, busy=0, overrun=0; a frame in progress SHALL be abandoned.

Structure
REQ-017 FSM state encoding and a BCD width function SHALL live in shared package adc_pkg.
REQ-018 The BCD converter SHALL be sub-module bin2bcd_seq (start/done handshake, parameters IN_W, DIGITS).

Verification
REQ-019 DATA_W=8 defaults, start pulse, ADC sends 0xFF -> res_bin=33, res_bcd=0x033, adc_csn low exactly 11 rise_en edges.
REQ-020 ADC sends 0x80 -> res_bin=16, res_bcd=0x016; ADC sends 0x00 -> res_bin=0, res_bcd=0x000.
REQ-021 AVG_LOG2=2, codes 10,20,30,40 -> res_raw=25, res_bin=3, exactly four frames with QUIET gaps.
REQ-022 cont=1, res_ready=0 for two results -> second result visible, overrun=1; res_ready=1 then clears res_valid next edge.
REQ-023 Assert rst_n_in mid-SHIFT -> adc_csn=1, adc_clk=0 without waiting for clk_in edge; next start produces a correct full frame.
REQ-024 DATA_W=12, SCALE=4096, SHIFT=10, DIGITS=3, code 0xFFF -> res_bcd saturates 0x999.
